control_fsm: RTL and testbench

Multi-cycle instruction sequencer that sits directly upstream of the datapath. It fetches 16-bit instruction words from memory port A and latches them into an instruction register. It then drives every datapath control line: register-mux selects, ALU opcode, immediate, register-write one-hot, memory write, PC increment/load, write-back source and flag enable. It also owns the processor status register (PSR) that conditional jumps test.

---
 rtl/control_fsm.sv | 237 +++++++++++++++++++++++
 tb/tb_control_fsm.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle instruction sequencer; fetches into IR, drives datapath controls, owns the PSR.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXEC), 4 for LOAD (adds LDWB); HALT is terminal until reset.
// Backpressure: none; the sequencer never stalls, and memory is a fixed one-cycle registered read.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset (state FETCH, IR=0, PSR=0)
//   mem_out_a[15:0]   memory port A read data, valid the cycle after the address
//   flags[4:0]        live ALU flags {N,Z,F,L,C}
//   opcode, imm       ALU operation word and immediate operand
//   imm_sel           ALU B operand from imm
//   mux_a_sel/_b_sel  register file read selects
//   reg_en[15:0]      one-hot register write enable; wb_sel picks ALU bus (0) or mem_out_a (1)
//   w_en_a            memory port A write
//   pc_sel            memory A address from PC (1) or register A (0)
//   pc_en, pc_ld      PC advance / load from register A[9:0]
//   flag_en, psr      PSR capture strobe and current PSR
//   halted            high in HALT
module control_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_out_a,
    input  logic [4:0]  flags,
    output logic [15:0] opcode,
    output logic [15:0] imm,
    output logic        imm_sel,
    output logic [3:0]  mux_a_sel,
    output logic [3:0]  mux_b_sel,
    output logic [15:0] reg_en,
    output logic        wb_sel,
    output logic        w_en_a,
    output logic        pc_sel,
    output logic        pc_en,
    output logic        pc_ld,
    output logic        flag_en,
    output logic [4:0]  psr,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_LDWB   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // PSR bit positions, matching the flags input.
    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;

    // ------------------------------------------------------------------
    // Instruction field split and class decode (pure functions of IR)
    // ------------------------------------------------------------------
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] ext;
    logic [3:0] rs;

    assign op  = ir[15:12];
    assign rd  = ir[11:8];
    assign ext = ir[7:4];
    assign rs  = ir[3:0];

    logic is_alu_reg;
    logic is_imm_sx;
    logic is_imm_zx;
    logic is_alu_cls;
    logic is_cmp;
    logic is_load;
    logic is_stor;
    logic is_jcond;
    logic is_halt;

    assign is_alu_reg = (op == 4'b0000);
    assign is_imm_sx  = (op == 4'b0101) || (op == 4'b1001) ||
                        (op == 4'b1011) || (op == 4'b1101);
    assign is_imm_zx  = (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0011);
    assign is_alu_cls = is_alu_reg || is_imm_sx || is_imm_zx;

    // CMP (register form, ext 1011) and CMPI (op 1011) only update flags.
    assign is_cmp     = (is_alu_reg && (ext == 4'b1011)) || (op == 4'b1011);

    assign is_load    = (op == 4'b0100) && (ext == 4'b0000);
    assign is_stor    = (op == 4'b0100) && (ext == 4'b0100);
    assign is_jcond   = (op == 4'b0100) && (ext == 4'b1100);
    assign is_halt    = (op == 4'b1111);

    // The ALU sees the whole IR for its classes; anything else gets a
    // neutral zero word so the ALU does not chase stray encodings.
    assign opcode = is_alu_cls ? ir : 16'h0000;

    always_comb begin
        imm = 16'h0000;
        if (is_imm_sx) begin
            imm = {{8{ir[7]}}, ir[7:0]};
        end else if (is_imm_zx) begin
            imm = {8'h00, ir[7:0]};
        end
    end

    // ------------------------------------------------------------------
    // Jump condition, evaluated against the stored PSR so that a jump
    // right after a compare sees that compare's result.
    // ------------------------------------------------------------------
    logic cond_true;

    always_comb begin
        cond_true = 1'b0;
        case (rd)
            4'b0000: cond_true =  psr[PSR_Z];
            4'b0001: cond_true = ~psr[PSR_Z];
            4'b0010: cond_true =  psr[PSR_C];
            4'b0011: cond_true = ~psr[PSR_C];
            4'b0100: cond_true =  psr[PSR_N];
            4'b0101: cond_true = ~psr[PSR_N];
            4'b0110: cond_true =  psr[PSR_F];
            4'b0111: cond_true = ~psr[PSR_F];
            4'b1000: cond_true =  psr[PSR_L];
            4'b1001: cond_true = ~psr[PSR_L];
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    logic [15:0] rd_onehot;
    assign rd_onehot = 16'h0001 << rd;

    // ------------------------------------------------------------------
    // State register, instruction register and PSR
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            ir    <= 16'h0000;
            psr   <= 5'b00000;
        end else begin
            state <= state_nxt;
            // Memory read data for the PC address issued in FETCH is
            // valid during DECODE.
            if (state == S_DECODE) begin
                ir <= mem_out_a;
            end
            if (flag_en) begin
                psr <= flags;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore outputs. Every enable defaults low, so an
    // asynchronous reset (which forces FETCH) drops in-flight writes in
    // the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        imm_sel   = 1'b0;
        mux_a_sel = 4'h0;
        mux_b_sel = 4'h0;
        reg_en    = 16'h0000;
        wb_sel    = 1'b0;
        w_en_a    = 1'b0;
        pc_sel    = 1'b1;
        pc_en     = 1'b0;
        pc_ld     = 1'b0;
        flag_en   = 1'b0;
        halted    = 1'b0;

        case (state)
            S_FETCH: begin
                state_nxt = S_DECODE;
            end

            S_DECODE: begin
                state_nxt = S_EXEC;
            end

            S_EXEC: begin
                state_nxt = S_FETCH;
                if (is_alu_cls) begin
                    mux_a_sel = rd;
                    mux_b_sel = rs;
                    imm_sel   = is_imm_sx || is_imm_zx;
                    reg_en    = is_cmp ? 16'h0000 : rd_onehot;
                    flag_en   = 1'b1;
                    pc_en     = 1'b1;
                end else if (is_load) begin
                    // Address the memory with rs; data returns in LDWB.
                    pc_sel    = 1'b0;
                    mux_a_sel = rs;
                    state_nxt = S_LDWB;
                end else if (is_stor) begin
                    pc_sel    = 1'b0;
                    mux_a_sel = rs;
                    mux_b_sel = rd;
                    w_en_a    = 1'b1;
                    pc_en     = 1'b1;
                end else if (is_jcond) begin
                    mux_a_sel = rs;
                    pc_en     = 1'b1;
                    pc_ld     = cond_true;
                end else if (is_halt) begin
                    // PC stays on the HALT word.
                    state_nxt = S_HALT;
                end else begin
                    pc_en     = 1'b1;
                end
            end

            S_LDWB: begin
                // Keep the load address on port A so mem_out_a stays valid.
                state_nxt = S_FETCH;
                pc_sel    = 1'b0;
                mux_a_sel = rs;
                wb_sel    = 1'b1;
                reg_en    = rd_onehot;
                pc_en     = 1'b1;
            end

            S_HALT: begin
                state_nxt = S_HALT;
                halted    = 1'b1;
            end

            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: drives an instruction stream into control_fsm and checks every output every cycle.
// Latency: expectations follow the per-class cycle counts (3, 4 for LOAD, HALT terminal).
// Backpressure: none; the bench plays memory and the ALU flags directly.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_out_a;
    logic [4:0]  flags;
    logic [15:0] opcode;
    logic [15:0] imm;
    logic        imm_sel;
    logic [3:0]  mux_a_sel;
    logic [3:0]  mux_b_sel;
    logic [15:0] reg_en;
    logic        wb_sel;
    logic        w_en_a;
    logic        pc_sel;
    logic        pc_en;
    logic        pc_ld;
    logic        flag_en;
    logic [4:0]  psr;
    logic        halted;

    control_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .mem_out_a (mem_out_a),
        .flags     (flags),
        .opcode    (opcode),
        .imm       (imm),
        .imm_sel   (imm_sel),
        .mux_a_sel (mux_a_sel),
        .mux_b_sel (mux_b_sel),
        .reg_en    (reg_en),
        .wb_sel    (wb_sel),
        .w_en_a    (w_en_a),
        .pc_sel    (pc_sel),
        .pc_en     (pc_en),
        .pc_ld     (pc_ld),
        .flag_en   (flag_en),
        .psr       (psr),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {K_ALU, K_SX, K_ZX, K_LOAD, K_STOR, K_JMP, K_HALT, K_NOP} kind_t;

    typedef struct packed {
        logic [15:0] opcode;
        logic [15:0] imm;
        logic        imm_sel;
        logic [3:0]  ma;
        logic [3:0]  mb;
        logic [15:0] reg_en;
        logic        wb_sel;
        logic        w_en_a;
        logic        pc_sel;
        logic        pc_en;
        logic        pc_ld;
        logic        flag_en;
        logic        halted;
    } exp_t;

    // Phases of an instruction as the bench counts them.
    localparam int PH_FETCH = 0, PH_DECODE = 1, PH_EXEC = 2, PH_LDWB = 3, PH_HALT = 4;

    logic [15:0] m_ir;
    logic [4:0]  m_psr;

    function automatic kind_t kind_of(input logic [15:0] w);
        logic [3:0] op;
        logic [3:0] ext;
        op  = w[15:12];
        ext = w[7:4];
        case (op)
            4'h0:                   return K_ALU;
            4'h5, 4'h9, 4'hB, 4'hD: return K_SX;
            4'h1, 4'h2, 4'h3:       return K_ZX;
            4'hF:                   return K_HALT;
            4'h4: begin
                if (ext == 4'h0) return K_LOAD;
                if (ext == 4'h4) return K_STOR;
                if (ext == 4'hC) return K_JMP;
                return K_NOP;
            end
            default:                return K_NOP;
        endcase
    endfunction

    // Conditions come in (true, false) pairs over Z, C, N, F, L.
    function automatic bit cond_holds(input logic [3:0] c, input logic [4:0] p);
        int pos;
        if (c == 4'hE) return 1'b1;
        if (c > 4'h9) return 1'b0;
        case (int'(c) / 2)
            0:       pos = 3;
            1:       pos = 0;
            2:       pos = 4;
            3:       pos = 2;
            default: pos = 1;
        endcase
        return p[pos] == !c[0];
    endfunction

    function automatic exp_t model(input int phase, input logic [15:0] w, input logic [4:0] p);
        exp_t  e;
        kind_t k;
        logic [3:0] rd;
        logic [3:0] rs;
        bit    only_flags;
        k  = kind_of(w);
        rd = w[11:8];
        rs = w[3:0];
        only_flags = (k == K_ALU && w[7:4] == 4'hB) || (w[15:12] == 4'hB);
        e = '0;
        e.pc_sel = 1'b1;
        if (k == K_ALU || k == K_SX || k == K_ZX) e.opcode = w;
        if (k == K_SX) e.imm = 16'($signed(w[7:0]));
        if (k == K_ZX) e.imm = {8'h00, w[7:0]};
        if (phase == PH_EXEC) begin
            case (k)
                K_ALU, K_SX, K_ZX: begin
                    e.ma = rd; e.mb = rs;
                    e.imm_sel = (k != K_ALU);
                    e.reg_en  = only_flags ? 16'h0 : (16'd1 << rd);
                    e.flag_en = 1'b1; e.pc_en = 1'b1;
                end
                K_LOAD: begin e.pc_sel = 1'b0; e.ma = rs; end
                K_STOR: begin e.pc_sel = 1'b0; e.ma = rs; e.mb = rd; e.w_en_a = 1'b1; e.pc_en = 1'b1; end
                K_JMP:  begin e.ma = rs; e.pc_en = 1'b1; e.pc_ld = cond_holds(rd, p); end
                K_HALT: ;
                default: e.pc_en = 1'b1;
            endcase
        end else if (phase == PH_LDWB) begin
            e.pc_sel = 1'b0; e.ma = rs; e.wb_sel = 1'b1; e.reg_en = 16'd1 << rd; e.pc_en = 1'b1;
        end else if (phase == PH_HALT) begin
            e.halted = 1'b1;
        end
        return e;
    endfunction

    task automatic check_outputs(input string where, input exp_t e);
        check({where, ".opcode"},  opcode,            e.opcode);
        check({where, ".imm"},     imm,               e.imm);
        check({where, ".imm_sel"}, 16'(imm_sel),      16'(e.imm_sel));
        check({where, ".mux_a"},   16'(mux_a_sel),    16'(e.ma));
        check({where, ".mux_b"},   16'(mux_b_sel),    16'(e.mb));
        check({where, ".reg_en"},  reg_en,            e.reg_en);
        check({where, ".wb_sel"},  16'(wb_sel),       16'(e.wb_sel));
        check({where, ".w_en_a"},  16'(w_en_a),       16'(e.w_en_a));
        check({where, ".pc_sel"},  16'(pc_sel),       16'(e.pc_sel));
        check({where, ".pc_en"},   16'(pc_en),        16'(e.pc_en));
        check({where, ".pc_ld"},   16'(pc_ld),        16'(e.pc_ld));
        check({where, ".flag_en"}, 16'(flag_en),      16'(e.flag_en));
        check({where, ".halted"},  16'(halted),       16'(e.halted));
        check({where, ".psr"},     16'(psr),          16'(m_psr));
    endtask

    // One clock: drive inputs on the falling edge, check 1 ns later,
    // then advance the model across the following rising edge.
    task automatic cycle(input int phase, input logic [15:0] mem, input logic [4:0] fl);
        kind_t k;
        @(negedge clk);
        mem_out_a = mem;
        flags     = fl;
        #1;
        check_outputs($sformatf("ph%0d/ir%04h", phase, m_ir), model(phase, m_ir, m_psr));
        k = kind_of(m_ir);
        if (phase == PH_EXEC && (k == K_ALU || k == K_SX || k == K_ZX)) m_psr = fl;
        if (phase == PH_DECODE) m_ir = mem;
    endtask

    // Asynchronous reset: enables must fall immediately; release just
    // after a rising edge so the next full cycle is FETCH.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        m_ir  = 16'h0000;
        m_psr = 5'b00000;
        check_outputs(tag, model(PH_FETCH, 16'h0000, 5'b00000));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // fl_exec < 0: random flags in EXEC; abort: reset during EXEC.
    task automatic run_instr(input logic [15:0] w, input int fl_exec, input bit abort);
        int n;
        logic [15:0] mem;
        logic [4:0]  fl;
        n = (kind_of(w) == K_LOAD) ? 4 : 3;
        for (int p = 0; p < n; p++) begin
            mem = (p == PH_DECODE) ? w : 16'($urandom);
            fl  = (p == PH_EXEC && fl_exec >= 0) ? 5'(fl_exec) : 5'($urandom);
            cycle(p, mem, fl);
            if (abort && p == PH_EXEC) begin
                do_reset("abort");
                return;
            end
        end
    endtask

    function automatic logic [15:0] gen_instr();
        logic [15:0] r;
        logic [3:0]  nop_ops [6];
        logic [3:0]  sx_ops [4];
        nop_ops = '{4'h6, 4'h7, 4'h8, 4'hA, 4'hC, 4'hE};
        sx_ops  = '{4'h5, 4'h9, 4'hB, 4'hD};
        r = 16'($urandom);
        case ($urandom_range(0, 9))
            0:       return {4'h0, r[11:0]};
            1:       return {4'h0, r[11:8], 4'hB, r[3:0]};
            2:       return {sx_ops[$urandom_range(0, 3)], r[11:0]};
            3:       return {4'(1 + $urandom_range(0, 2)), r[11:0]};
            4:       return {4'h4, r[11:8], 4'h0, r[3:0]};
            5:       return {4'h4, r[11:8], 4'h4, r[3:0]};
            6, 7:    return {4'h4, r[11:8], 4'hC, r[3:0]};
            8:       return (r[15]) ? {nop_ops[$urandom_range(0, 5)], r[11:0]}
                                    : {4'h4, r[11:8], 4'h8, r[3:0]};
            default: return {4'hB, r[11:0]};
        endcase
    endfunction

    initial begin
        reset     = 1'b1;
        mem_out_a = 16'h0000;
        flags     = 5'b00000;
        m_ir      = 16'h0000;
        m_psr     = 5'b00000;
        #2;
        check_outputs("reset", model(PH_FETCH, 16'h0000, 5'b00000));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed instructions
        run_instr(16'h0152, -1, 1'b0);           // ADD r1,r2
        run_instr(16'h53F0, -1, 1'b0);           // ADDI r3,-16
        run_instr(16'h13F0, -1, 1'b0);           // ANDI r3,0xF0
        run_instr(16'h4704, -1, 1'b0);           // LOAD r7,[r4]
        run_instr(16'h4244, -1, 1'b0);           // STOR r2->[r4]
        run_instr(16'h00B1, 5'b01000, 1'b0);     // CMP with Z=1
        run_instr(16'h40C5, -1, 1'b0);           // JEQ r5: taken
        run_instr(16'h00B1, 5'b00000, 1'b0);     // CMP with Z=0
        run_instr(16'h40C5, -1, 1'b0);           // JEQ r5: not taken
        run_instr(16'h4EC3, -1, 1'b0);           // always
        run_instr(16'h4FC3, -1, 1'b0);           // never

        // Random stream
        for (int i = 0; i < 400; i++) run_instr(gen_instr(), -1, 1'b0);

        // Reset in the middle of an ADD's EXEC, then carry on
        run_instr(16'h0152, 5'b11111, 1'b1);
        for (int i = 0; i < 40; i++) run_instr(gen_instr(), -1, 1'b0);

        // HALT holds until reset
        run_instr(16'hF000, -1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(PH_HALT, 16'($urandom), 5'($urandom));
        do_reset("post_halt");
        for (int i = 0; i < 10; i++) run_instr(gen_instr(), -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
